bitcnt_unit: RTL and testbench

Pipelined execution unit for the RV64 Zbb `cpop` and `cpopw` instructions in the integer execute cluster. It accepts a source operand and its ROB/PRF tags from issue and masks the operand for the word form. It splits the operand into 16-bit slices, each counted by a `popcount #(4)` instance, then reduces the slice counts and returns a 64-bit zero-extended result to writeback. A valid/ready handshake on both sides and a flush input make it a self-contained 3-stage pipeline.

---
 rtl/bitcnt_unit.sv | 146 ++++++++++++++
 tb/tb_bitcnt_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcnt_unit.sv
// bitcnt_unit: 3-stage elastic pipeline for RV64 Zbb cpop/cpopw.
// Ports: clk/reset_n, flush, in_* issue handshake, out_* writeback handshake.

module popcount #(
  parameter int LOG_W = 4
) (
  input  logic [(1<<LOG_W)-1:0] din,
  output logic [LOG_W:0]        cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < (1 << LOG_W); i++) begin
      cnt = cnt + {{LOG_W{1'b0}}, din[i]};
    end
  end

endmodule

module bitcnt_unit #(
  parameter int W_ROB = 6,
  parameter int W_PRF = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_src,
  input  logic             in_word,
  input  logic [W_ROB-1:0] in_rob_ptr,
  input  logic [W_PRF-1:0] in_prf_ptr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [W_ROB-1:0] out_rob_ptr,
  output logic [W_PRF-1:0] out_prf_ptr
);

  localparam int W_TAG = W_ROB + W_PRF;

  logic             va_q, va_d;
  logic [63:0]      opa_q, opa_d;
  logic [W_TAG-1:0] taga_q, taga_d;

  logic             vb_q, vb_d;
  logic [3:0][4:0]  cnt_q, cnt_d;
  logic [W_TAG-1:0] tagb_q, tagb_d;

  logic             vc_q, vc_d;
  logic [6:0]       sum_q, sum_d;
  logic [W_TAG-1:0] tagc_q, tagc_d;

  logic [3:0][4:0]  slice_cnt;
  logic             adv_a, adv_b, adv_c;
  logic             accept;

  for (genvar g = 0; g < 4; g++) begin : g_pc
    popcount #(4) u_pc (
      .din (opa_q[16*g +: 16]),
      .cnt (slice_cnt[g])
    );
  end

  // Each stage may move when it is empty or its consumer moves.
  assign adv_c    = !vc_q | out_ready;
  assign adv_b    = !vb_q | adv_c;
  assign adv_a    = !va_q | adv_b;
  assign in_ready = adv_a & !flush & reset_n;
  assign accept   = in_valid & in_ready;

  always_comb begin
    va_d   = va_q;
    opa_d  = opa_q;
    taga_d = taga_q;
    vb_d   = vb_q;
    cnt_d  = cnt_q;
    tagb_d = tagb_q;
    vc_d   = vc_q;
    sum_d  = sum_q;
    tagc_d = tagc_q;

    if (adv_a) begin
      va_d = accept;
      if (accept) begin
        opa_d  = in_word ? {32'b0, in_src[31:0]} : in_src;
        taga_d = {in_rob_ptr, in_prf_ptr};
      end
    end

    if (adv_b) begin
      vb_d = va_q;
      if (va_q) begin
        cnt_d  = slice_cnt;
        tagb_d = taga_q;
      end
    end

    if (adv_c) begin
      vc_d = vb_q;
      if (vb_q) begin
        sum_d  = {2'b0, cnt_q[0]} + {2'b0, cnt_q[1]}
               + {2'b0, cnt_q[2]} + {2'b0, cnt_q[3]};
        tagc_d = tagb_q;
      end
    end

    // A C-stage handshake in the flush cycle still completes
    // because out_valid is the registered vC.
    if (flush) begin
      va_d = 1'b0;
      vb_d = 1'b0;
      vc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      va_q   <= 1'b0;
      opa_q  <= '0;
      taga_q <= '0;
      vb_q   <= 1'b0;
      cnt_q  <= '0;
      tagb_q <= '0;
      vc_q   <= 1'b0;
      sum_q  <= '0;
      tagc_q <= '0;
    end else begin
      va_q   <= va_d;
      opa_q  <= opa_d;
      taga_q <= taga_d;
      vb_q   <= vb_d;
      cnt_q  <= cnt_d;
      tagb_q <= tagb_d;
      vc_q   <= vc_d;
      sum_q  <= sum_d;
      tagc_q <= tagc_d;
    end
  end

  assign out_valid   = vc_q;
  assign out_data    = {57'b0, sum_q};
  assign out_rob_ptr = tagc_q[W_TAG-1:W_PRF];
  assign out_prf_ptr = tagc_q[W_PRF-1:0];

endmodule

// File: tb/tb_bitcnt_unit.sv
// tb_bitcnt_unit: scoreboard bench for bitcnt_unit.
// Scenario tasks plus a negedge monitor checking every output handshake.

module tb_bitcnt_unit;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_src;
  logic        in_word;
  logic [5:0]  in_rob_ptr;
  logic [6:0]  in_prf_ptr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [5:0]  out_rob_ptr;
  logic [6:0]  out_prf_ptr;

  typedef struct packed {
    logic [63:0] data;
    logic [5:0]  rob;
    logic [6:0]  prf;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  bitcnt_unit #(.W_ROB(6), .W_PRF(7)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_src      (in_src),
    .in_word     (in_word),
    .in_rob_ptr  (in_rob_ptr),
    .in_prf_ptr  (in_prf_ptr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rob_ptr (out_rob_ptr),
    .out_prf_ptr (out_prf_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: push on accept, pop on output handshake.
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] m;
    if (reset_n) begin
      if (out_valid && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_spurious: got data=%0d rob=%0d, required no result",
                   out_data, out_rob_ptr);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_rob_ptr !== e.rob ||
              out_prf_ptr !== e.prf) begin
            n_err++;
            $display("FAIL sb_result: got d=%0d r=%0d p=%0d, required d=%0d r=%0d p=%0d",
                     out_data, out_rob_ptr, out_prf_ptr, e.data, e.rob, e.prf);
          end
        end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready) begin
        m = in_word ? {32'b0, in_src[31:0]} : in_src;
        e.data = 64'($countones(m));
        e.rob  = in_rob_ptr;
        e.prf  = in_prf_ptr;
        sb.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic [63:0] s,
                       input logic w, input logic [5:0] r);
    in_valid   = v;
    in_src     = s;
    in_word    = w;
    in_rob_ptr = r;
    in_prf_ptr = {1'b1, r};
  endtask

  task automatic test_reset;
    logic [63:0] src [3];
    src[0] = 64'h00FF; src[1] = 64'h1234; src[2] = 64'hF0F0_0000_0000_0001;
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 64'h0, 1'b0, 6'd0);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'h0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b d=%0h, required 0 0 0",
               in_ready, out_valid, out_data);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, src[i], 1'b0, 6'(i + 1));
      @(posedge clk); #1;
    end
    drive(1'b0, 64'h0, 1'b0, 6'd0);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 64'd8) begin
      n_err++;
      $display("FAIL reset_prefill: got vld=%b d=%0d, required 1 8",
               out_valid, out_data);
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      n_err++;
      $display("FAIL reset_async: got vld=%b d=%0d, required 0 0",
               out_valid, out_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 64'hF, 1'b0, 6'd5);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_accept: got rdy=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 1'b0, 6'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (k < 3 && out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL latency_early: cycle %0d got vld=1, required 0", k);
      end else if (k == 3 && (out_valid !== 1'b1 || out_data !== 64'd4)) begin
        n_err++;
        $display("FAIL latency_result: got vld=%b d=%0d, required 1 4",
                 out_valid, out_data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_seq(input string nm, input logic [63:0] s [4],
                         input logic w [4], input logic [63:0] ex [4],
                         input int n);
    out_ready = 1'b1;
    for (int c = 0; c < n + 4; c++) begin
      if (c < n) drive(1'b1, s[c], w[c], 6'(c + 10));
      else drive(1'b0, 64'h0, 1'b0, 6'd0);
      @(negedge clk);
      if (c < n) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL %s_accept: op %0d got rdy=%b, required 1", nm, c, in_ready);
        end
      end
      if (c >= 3 && c < n + 3) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== ex[c-3] ||
            out_rob_ptr !== 6'(c + 7)) begin
          n_err++;
          $display("FAIL %s_out: op %0d got v=%b d=%0d r=%0d, required 1 %0d %0d",
                   nm, c - 3, out_valid, out_data, out_rob_ptr, ex[c-3], c + 7);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_corners;
    logic [63:0] s [4];
    logic        w [4];
    logic [63:0] ex [4];
    s[0] = 64'h0;                   ex[0] = 64'd0;
    s[1] = 64'hFFFF_FFFF_FFFF_FFFF; ex[1] = 64'd64;
    s[2] = 64'h8000_0000_0000_0001; ex[2] = 64'd2;
    s[3] = 64'hAAAA_5555_0F0F_F0F0; ex[3] = 64'd32;
    for (int i = 0; i < 4; i++) w[i] = 1'b0;
    run_seq("corner", s, w, ex, 4);
  endtask

  task automatic test_word;
    logic [63:0] s [4];
    logic        w [4];
    logic [63:0] ex [4];
    for (int i = 0; i < 4; i++) begin
      s[i] = 64'hFFFF_FFFF_0000_0003; w[i] = 1'b0; ex[i] = 64'd0;
    end
    w[0] = 1'b1; ex[0] = 64'd2;
    ex[1] = 64'd34;
    run_seq("word", s, w, ex, 2);
  endtask

  task automatic test_backpressure;
    int acc;
    logic [63:0] snap;
    acc = 0;
    snap = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 64'h1 << (c * 3), 1'b0, 6'(20 + c));
      @(negedge clk);
      if (in_ready) acc++;
      if (c == 3) snap = out_data;
      if (c > 3) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== snap) begin
          n_err++;
          $display("FAIL bp_stable: got v=%b d=%0d, required 1 %0d",
                   out_valid, out_data, snap);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_vec++;
    if (acc !== 3 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_capacity: got acc=%0d rdy=%b, required 3 0", acc, in_ready);
    end
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 1'b0, 6'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL bp_release: got rdy=%b, required 1", in_ready);
        end
      end
      n_vec++;
      if (out_valid !== (c < 3)) begin
        n_err++;
        $display("FAIL bp_drain: cycle %0d got v=%b, required %0d",
                 c, out_valid, c < 3);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 64'h3 << (i * 8), 1'b0, 6'(i));
      @(posedge clk); #1;
    end
    drive(1'b1, 64'hFF, 1'b0, 6'd4);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_rob_ptr !== 6'd1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_cycle: got v=%b r=%0d rdy=%b, required 1 1 0",
               out_valid, out_rob_ptr, in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 6'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_after: cycle %0d got v=1 r=%0d, required 0",
                 c, out_rob_ptr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [63:0] s;
    for (int c = 0; c < 10000; c++) begin
      s = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: s = '0;
        1: s = '1;
        default: ;
      endcase
      drive(($urandom_range(0, 3) != 0), s, $urandom_range(0, 1) == 1,
            6'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    drive(1'b0, 64'h0, 1'b0, 6'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain: got left=%0d v=%b, required 0 0",
               sb.size(), out_valid);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_corners();
    test_word();
    test_backpressure();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
